// File: rtl/operand_fetch_stage_if.sv
//------------------------------------------------------------------------------
// operand_fetch_stage_if
// Decode, register-file, bypass and execute-side signals of the operand fetch stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface operand_fetch_stage_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_ra1;
  logic [AW-1:0] in_ra2;
  logic [AW-1:0] in_wa;
  logic          in_we;
  logic          in_is_load;
  logic [AW-1:0] rf_ra1;
  logic [AW-1:0] rf_ra2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic          wb_we;
  logic [AW-1:0] wb_wa;
  logic [DW-1:0] wb_wd;
  logic          ex_fwd_valid;
  logic [AW-1:0] ex_fwd_wa;
  logic [DW-1:0] ex_fwd_wd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_op1;
  logic [DW-1:0] out_op2;
  logic [AW-1:0] out_wa;
  logic          out_we;
  logic          out_is_load;
  logic [15:0]   stall_count;

  modport master (
    output in_valid, in_ra1, in_ra2, in_wa, in_we, in_is_load,
    output rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd,
    output ex_fwd_valid, ex_fwd_wa, ex_fwd_wd, out_ready,
    input  in_ready, rf_ra1, rf_ra2, out_valid, out_op1, out_op2,
    input  out_wa, out_we, out_is_load, stall_count
  );

  modport slave (
    input  in_valid, in_ra1, in_ra2, in_wa, in_we, in_is_load,
    input  rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd,
    input  ex_fwd_valid, ex_fwd_wa, ex_fwd_wd, out_ready,
    output in_ready, rf_ra1, rf_ra2, out_valid, out_op1, out_op2,
    output out_wa, out_we, out_is_load, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
//------------------------------------------------------------------------------
// operand_fetch_stage
// Scoreboarded operand fetch with writeback bypass; define OPFETCH_EX_FWD_EN to
// also bypass from the execute result.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module operand_fetch_stage #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  operand_fetch_stage_if.slave       bus
);
  localparam int c_NREG = 1 << AW;

  logic [c_NREG-1:0] r_pending;
  logic [c_NREG-1:0] w_pending_nxt;
  logic [DW-1:0]     w_op1;
  logic [DW-1:0]     w_op2;
  logic              w_unres1;
  logic              w_unres2;
  logic              w_ex_hit1;
  logic              w_ex_hit2;
  logic              w_wb_hit1;
  logic              w_wb_hit2;
  logic              w_waw;
  logic              w_hazard;
  logic              w_accept;

  assign bus.rf_ra1 = bus.in_ra1;
  assign bus.rf_ra2 = bus.in_ra2;

`ifdef OPFETCH_EX_FWD_EN
  assign w_ex_hit1 = r_pending[bus.in_ra1] && bus.ex_fwd_valid && (bus.ex_fwd_wa == bus.in_ra1);
  assign w_ex_hit2 = r_pending[bus.in_ra2] && bus.ex_fwd_valid && (bus.ex_fwd_wa == bus.in_ra2);
`else
  logic w_unused_ex;
  assign w_unused_ex = ^{bus.ex_fwd_valid, bus.ex_fwd_wa, bus.ex_fwd_wd};
  assign w_ex_hit1   = 1'b0;
  assign w_ex_hit2   = 1'b0;
`endif

  assign w_wb_hit1 = bus.wb_we && (bus.wb_wa == bus.in_ra1);
  assign w_wb_hit2 = bus.wb_we && (bus.wb_wa == bus.in_ra2);

  always_comb begin
    w_op1    = bus.rf_rd1;
    w_unres1 = 1'b0;
    if (w_ex_hit1)                   w_op1    = bus.ex_fwd_wd;
    else if (w_wb_hit1)              w_op1    = bus.wb_wd;
    else if (r_pending[bus.in_ra1])  w_unres1 = 1'b1;
  end

  always_comb begin
    w_op2    = bus.rf_rd2;
    w_unres2 = 1'b0;
    if (w_ex_hit2)                   w_op2    = bus.ex_fwd_wd;
    else if (w_wb_hit2)              w_op2    = bus.wb_wd;
    else if (r_pending[bus.in_ra2])  w_unres2 = 1'b1;
  end

  // One writer per register in flight: a second writer waits for the first's writeback.
  assign w_waw    = bus.in_we && r_pending[bus.in_wa] &&
                    !(bus.wb_we && (bus.wb_wa == bus.in_wa));
  assign w_hazard = w_unres1 || w_unres2 || w_waw;

  assign bus.in_ready = !w_hazard && (!bus.out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Set is applied after clear so a same-index set wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.wb_we)               w_pending_nxt[bus.wb_wa] = 1'b0;
    if (w_accept && bus.in_we)   w_pending_nxt[bus.in_wa] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending       <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_op1     <= '0;
      bus.out_op2     <= '0;
      bus.out_wa      <= '0;
      bus.out_we      <= 1'b0;
      bus.out_is_load <= 1'b0;
      bus.stall_count <= 16'h0000;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_accept) begin
        bus.out_valid   <= 1'b1;
        bus.out_op1     <= w_op1;
        bus.out_op2     <= w_op2;
        bus.out_wa      <= bus.in_wa;
        bus.out_we      <= bus.in_we;
        bus.out_is_load <= bus.in_is_load;
      end else if (bus.out_ready) begin
        bus.out_valid   <= 1'b0;
      end
      if (bus.in_valid && w_hazard && (bus.stall_count != 16'hFFFF))
        bus.stall_count <= bus.stall_count + 16'h0001;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
//------------------------------------------------------------------------------
// tb_operand_fetch_stage
// Directed bench for operand_fetch_stage with a small register-file model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_operand_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_stall = 0;
  logic [31:0] rf [64];

  always #5 clk = ~clk;

  operand_fetch_stage_if #(.AW(6), .DW(32)) bus ();

  operand_fetch_stage #(.AW(6), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file written by the same writeback port the stage bypasses from.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) rf[i] <= 32'h1000 + i;
      rf[3] <= 32'h11;
      rf[4] <= 32'h22;
    end else if (bus.wb_we) begin
      rf[bus.wb_wa] <= bus.wb_wd;
    end
  end

  assign bus.rf_rd1 = rf[bus.rf_ra1];
  assign bus.rf_rd2 = rf[bus.rf_ra2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [5:0] ra1, input logic [5:0] ra2,
                     input logic [5:0] wa, input logic we);
    bus.in_valid   = 1'b1;
    bus.in_ra1     = ra1;
    bus.in_ra2     = ra2;
    bus.in_wa      = wa;
    bus.in_we      = we;
    bus.in_is_load = 1'b0;
  endtask

  task automatic wb(input logic we, input logic [5:0] wa, input logic [31:0] wd);
    bus.wb_we = we;
    bus.wb_wa = wa;
    bus.wb_wd = wd;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_ra1 = '0; bus.in_ra2 = '0; bus.in_wa = '0;
    bus.in_we = 1'b0; bus.in_is_load = 1'b0; bus.out_ready = 1'b1;
    bus.ex_fwd_valid = 1'b0; bus.ex_fwd_wa = '0; bus.ex_fwd_wd = '0;
    wb(1'b0, 6'd0, 32'h0);

    // Reset state
    tick(); tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_op1", 64'(bus.out_op1), 64'd0);
    check("rst_stall", 64'(bus.stall_count), 64'd0);
    check("rst_pending", dut.r_pending, 64'd0);
    rst = 1'b0;
    tick();

    // Plain read of registers 3 and 4
    req(6'd3, 6'd4, 6'd0, 1'b0);
    #1;
    check("basic_ready", 64'(bus.in_ready), 64'd1);
    check("rf_ra1_copy", 64'(bus.rf_ra1), 64'd3);
    tick();
    check("basic_valid", 64'(bus.out_valid), 64'd1);
    check("basic_op1", 64'(bus.out_op1), 64'h11);
    check("basic_op2", 64'(bus.out_op2), 64'h22);
    check("basic_pending", dut.r_pending, 64'd0);
    bus.in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // Dependency on register 5 with an execute result available
    req(6'd0, 6'd0, 6'd5, 1'b1);
    tick();
    check("issue5_pending", dut.r_pending, 64'h20);
    check("issue5_wa", 64'(bus.out_wa), 64'd5);
    req(6'd5, 6'd4, 6'd0, 1'b0);
    bus.ex_fwd_valid = 1'b1; bus.ex_fwd_wa = 6'd5; bus.ex_fwd_wd = 32'hDEAD;
    #1;
`ifdef OPFETCH_EX_FWD_EN
    check("exfwd_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check("exfwd_op1", 64'(bus.out_op1), 64'hDEAD);
    check("exfwd_op2", 64'(bus.out_op2), 64'h22);
    bus.in_valid = 1'b0; bus.ex_fwd_valid = 1'b0;
    wb(1'b1, 6'd5, 32'hDEAD);
    tick();
    wb(1'b0, 6'd0, 32'h0);
    check("exfwd_pending", dut.r_pending, 64'd0);
`else
    check("noexfwd_ready", 64'(bus.in_ready), 64'd0);
    tick(); exp_stall++;
    check("noexfwd_stall1", 64'(bus.stall_count), 64'(exp_stall));
    tick(); exp_stall++;
    check("noexfwd_stall2", 64'(bus.stall_count), 64'(exp_stall));
    bus.ex_fwd_valid = 1'b0;
    wb(1'b1, 6'd5, 32'h1234);
    #1;
    check("noexfwd_wb_ready", 64'(bus.in_ready), 64'd1);
    tick();
    wb(1'b0, 6'd0, 32'h0);
    bus.in_valid = 1'b0;
    check("noexfwd_op1", 64'(bus.out_op1), 64'h1234);
    check("noexfwd_pending", dut.r_pending, 64'd0);
`endif
    check("r5_stall_total", 64'(bus.stall_count), 64'(exp_stall));

    // Writeback bypass in the same cycle as the read of register 7
    req(6'd0, 6'd0, 6'd7, 1'b1);
    tick();
    req(6'd7, 6'd7, 6'd0, 1'b0);
    wb(1'b1, 6'd7, 32'hBEEF);
    #1;
    check("wbbyp_ready", 64'(bus.in_ready), 64'd1);
    tick();
    wb(1'b0, 6'd0, 32'h0);
    bus.in_valid = 1'b0;
    check("wbbyp_op1", 64'(bus.out_op1), 64'hBEEF);
    check("wbbyp_op2", 64'(bus.out_op2), 64'hBEEF);
    check("wbbyp_pending", dut.r_pending, 64'd0);

    // WAW on register 9
    req(6'd0, 6'd0, 6'd9, 1'b1);
    tick();
    req(6'd3, 6'd4, 6'd9, 1'b1);
    #1;
    check("waw_ready0", 64'(bus.in_ready), 64'd0);
    tick(); exp_stall++;
    tick(); exp_stall++;
    check("waw_ready1", 64'(bus.in_ready), 64'd0);
    check("waw_stall", 64'(bus.stall_count), 64'(exp_stall));
    wb(1'b1, 6'd9, 32'h900);
    #1;
    check("waw_wb_ready", 64'(bus.in_ready), 64'd1);
    tick();
    wb(1'b0, 6'd0, 32'h0);
    bus.in_valid = 1'b0;
    check("waw_valid", 64'(bus.out_valid), 64'd1);
    check("waw_wa", 64'(bus.out_wa), 64'd9);
    check("waw_op1", 64'(bus.out_op1), 64'h11);
    check("waw_pending_set_wins", dut.r_pending, 64'h200);
    wb(1'b1, 6'd9, 32'h901);
    tick();
    wb(1'b0, 6'd0, 32'h0);
    check("waw_pending_clear", dut.r_pending, 64'd0);

    // Backpressure holds the output register
    bus.out_ready = 1'b0;
    req(6'd3, 6'd4, 6'd0, 1'b0);
    tick();
    check("bp_op1_first", 64'(bus.out_op1), 64'h11);
    req(6'd4, 6'd3, 6'd0, 1'b0);
    #1;
    check("bp_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    check("bp_hold_op1", 64'(bus.out_op1), 64'h11);
    check("bp_no_stall", 64'(bus.stall_count), 64'(exp_stall));
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check("bp_op1_second", 64'(bus.out_op1), 64'h22);

    // Asynchronous reset in the middle of a stall
    req(6'd3, 6'd4, 6'd10, 1'b1);
    tick();
    bus.out_ready = 1'b0;
    req(6'd10, 6'd4, 6'd0, 1'b0);
    tick(); exp_stall++;
    tick(); exp_stall++;
    check("mid_stall", 64'(bus.stall_count), 64'(exp_stall));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_op", 64'({bus.out_op1, bus.out_op2}), 64'd0);
    check("arst_fields", 64'({bus.out_wa, bus.out_we, bus.out_is_load}), 64'd0);
    check("arst_pending", dut.r_pending, 64'd0);
    check("arst_stall", 64'(bus.stall_count), 64'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    exp_stall = 0;
    tick();

    // Saturation of the stall counter
    req(6'd0, 6'd0, 6'd11, 1'b1);
    tick();
    req(6'd11, 6'd0, 6'd0, 1'b0);
    repeat (65534) tick();
    check("sat_fffe", 64'(bus.stall_count), 64'hFFFE);
    repeat (4466) tick();
    check("sat_ffff", 64'(bus.stall_count), 64'hFFFF);
    bus.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire
